// File: rtl/lvt_wr_scheduler.sv
// Write-side scheduler for a 2R2W LVT memory: init sweep after reset/request, then round-robin of 4 requesters onto 2 write ports.
// Latency: 1 cycle from valid&ready handshake to registered write strobe.
// Backpressure: req_ready is a same-cycle combinational grant; ungranted or address-conflicting requesters stay pending.
module lvt_wr_scheduler #(
    parameter int                BLOCKSIZE  = 10,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    req_valid,
    input  logic [4*(BLOCKSIZE+1)-1:0]    req_addr,
    input  logic [4*DATA_W-1:0]           req_data,
    output logic [3:0]                    req_ready,
    input  logic                          init_start,
    output logic                          init_done,
    output logic [BLOCKSIZE:0]            w_addr_1,
    output logic [DATA_W-1:0]             w_din_1,
    output logic                          w_enb_1,
    output logic [BLOCKSIZE:0]            w_addr_2,
    output logic [DATA_W-1:0]             w_din_2,
    output logic                          w_enb_2
);
    localparam int AW = BLOCKSIZE + 1;
    localparam logic [BLOCKSIZE-1:0] LAST_CNT = '1;
    localparam logic [BLOCKSIZE-1:0] CNT_ONE  = 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               r_state,    w_nxt_state;
    logic [BLOCKSIZE-1:0] r_init_cnt, w_nxt_cnt;
    logic [1:0]           r_rr_ptr,   w_nxt_rr;
    logic                 r_enb_1,    w_nxt_enb_1;
    logic                 r_enb_2,    w_nxt_enb_2;
    logic [AW-1:0]        r_addr_1,   w_nxt_addr_1;
    logic [AW-1:0]        r_addr_2,   w_nxt_addr_2;
    logic [DATA_W-1:0]    r_din_1,    w_nxt_din_1;
    logic [DATA_W-1:0]    r_din_2,    w_nxt_din_2;

    logic                 w_a_found, w_b_found;
    logic [1:0]           w_a_idx,   w_b_idx, w_idx, w_last;
    logic [AW-1:0]        w_a_addr,  w_b_addr, w_cur_addr;
    logic [DATA_W-1:0]    w_a_data,  w_b_data;
    logic [3:0]           w_ready;

    // Scan from rr_ptr; the second grant must not collide with the first grant's address.
    always_comb begin
        w_a_found  = 1'b0;
        w_b_found  = 1'b0;
        w_a_idx    = 2'd0;
        w_b_idx    = 2'd0;
        w_idx      = 2'd0;
        w_a_addr   = '0;
        w_b_addr   = '0;
        w_cur_addr = '0;
        w_a_data   = '0;
        w_b_data   = '0;
        for (int k = 0; k < 4; k++) begin
            w_idx      = r_rr_ptr + k[1:0];
            w_cur_addr = req_addr[w_idx*AW +: AW];
            if (req_valid[w_idx]) begin
                if (!w_a_found) begin
                    w_a_found = 1'b1;
                    w_a_idx   = w_idx;
                    w_a_addr  = w_cur_addr;
                    w_a_data  = req_data[w_idx*DATA_W +: DATA_W];
                end else if (!w_b_found && (w_cur_addr != w_a_addr)) begin
                    w_b_found = 1'b1;
                    w_b_idx   = w_idx;
                    w_b_addr  = w_cur_addr;
                    w_b_data  = req_data[w_idx*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_init_cnt;
        w_nxt_rr     = r_rr_ptr;
        w_nxt_enb_1  = 1'b0;
        w_nxt_enb_2  = 1'b0;
        w_nxt_addr_1 = r_addr_1;
        w_nxt_addr_2 = r_addr_2;
        w_nxt_din_1  = r_din_1;
        w_nxt_din_2  = r_din_2;
        w_ready      = 4'b0000;
        w_last       = w_b_found ? w_b_idx : w_a_idx;
        case (r_state)
            ST_INIT: begin
                w_nxt_enb_1  = 1'b1;
                w_nxt_enb_2  = 1'b1;
                w_nxt_addr_1 = {r_init_cnt, 1'b0};
                w_nxt_addr_2 = {r_init_cnt, 1'b1};
                w_nxt_din_1  = INIT_VALUE;
                w_nxt_din_2  = INIT_VALUE;
                if (r_init_cnt == LAST_CNT) begin
                    w_nxt_state = ST_RUN;
                end else begin
                    w_nxt_cnt = r_init_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (init_start) begin
                    w_nxt_state = ST_INIT;
                    w_nxt_cnt   = '0;
                end else if (!rst) begin
                    if (w_a_found) begin
                        w_ready[w_a_idx] = 1'b1;
                        w_nxt_enb_1      = 1'b1;
                        w_nxt_addr_1     = w_a_addr;
                        w_nxt_din_1      = w_a_data;
                        w_nxt_rr         = w_last + 2'd1;
                    end
                    if (w_b_found) begin
                        w_ready[w_b_idx] = 1'b1;
                        w_nxt_enb_2      = 1'b1;
                        w_nxt_addr_2     = w_b_addr;
                        w_nxt_din_2      = w_b_data;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_INIT;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_rr_ptr   <= 2'd0;
            r_enb_1    <= 1'b0;
            r_enb_2    <= 1'b0;
            r_addr_1   <= '0;
            r_addr_2   <= '0;
            r_din_1    <= '0;
            r_din_2    <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_init_cnt <= w_nxt_cnt;
            r_rr_ptr   <= w_nxt_rr;
            r_enb_1    <= w_nxt_enb_1;
            r_enb_2    <= w_nxt_enb_2;
            r_addr_1   <= w_nxt_addr_1;
            r_addr_2   <= w_nxt_addr_2;
            r_din_1    <= w_nxt_din_1;
            r_din_2    <= w_nxt_din_2;
        end
    end

    assign req_ready = w_ready;
    assign init_done = (r_state == ST_RUN);
    assign w_enb_1   = r_enb_1;
    assign w_enb_2   = r_enb_2;
    assign w_addr_1  = r_addr_1;
    assign w_addr_2  = r_addr_2;
    assign w_din_1   = r_din_1;
    assign w_din_2   = r_din_2;

endmodule

// File: tb/tb_lvt_wr_scheduler.sv
// Directed bench for lvt_wr_scheduler with a behavioural 2-write-port memory for readback.
module tb_lvt_wr_scheduler;
    localparam int BS = 10;
    localparam int AW = BS + 1;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        req_valid = 4'b0000;
    logic [4*AW-1:0]   req_addr  = '0;
    logic [4*DW-1:0]   req_data  = '0;
    logic [3:0]        req_ready;
    logic              init_start = 1'b0;
    logic              init_done;
    logic [AW-1:0]     w_addr_1, w_addr_2;
    logic [DW-1:0]     w_din_1,  w_din_2;
    logic              w_enb_1,  w_enb_2;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:(2<<BS)-1];

    lvt_wr_scheduler #(.BLOCKSIZE(BS), .DATA_W(DW), .INIT_VALUE('0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .init_start(init_start), .init_done(init_done),
        .w_addr_1(w_addr_1), .w_din_1(w_din_1), .w_enb_1(w_enb_1),
        .w_addr_2(w_addr_2), .w_din_2(w_din_2), .w_enb_2(w_enb_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_enb_1) mem[w_addr_1] <= w_din_1;
        if (w_enb_2) mem[w_addr_2] <= w_din_2;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic chk_init_write(input int k);
        logic [AW-1:0] a0, a1;
        a0 = AW'(2*k);
        a1 = AW'(2*k+1);
        chk("init_write", {8'h0, w_enb_1, w_enb_2, w_addr_1, w_addr_2, w_din_1},
                          {8'h0, 1'b1, 1'b1, a0, a1, 32'h0});
    endtask

    initial begin
        #2 rst = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_req(i, AW'(100 + i), 32'h5A5A0000 + i);
        tick; tick;
        chk("rst_enb", {w_enb_1, w_enb_2}, 2'b00);
        chk("rst_addr", {w_addr_1, w_addr_2}, '0);
        chk("rst_din", {w_din_1, w_din_2}, '0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_ready", req_ready, 4'b0000);

        // Full sweep after reset release, with all requesters asking throughout INIT
        rst = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            tick;
            chk_init_write(k);
            chk("init_done", init_done, (k == 1023) ? 1'b1 : 1'b0);
            if (k < 1023) chk("init_ready", req_ready, 4'b0000);
            if (k == 1022) req_valid = 4'b0000;
        end

        // Single requester 2, rr_ptr=0
        set_req(2, 11'h005, 32'hDEADBEEF);
        req_valid = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        tick;
        chk("single_w1", {w_enb_1, w_addr_1, w_din_1}, {1'b1, 11'h005, 32'hDEADBEEF});
        chk("single_enb2", w_enb_2, 1'b0);

        // Requester 3 alone, returns rr_ptr to 0
        set_req(3, 11'h020, 32'h00000033);
        req_valid = 4'b1000;
        #1 chk("req3_ready", req_ready, 4'b1000);
        tick;
        chk("req3_w1", {w_enb_1, w_addr_1, w_din_1}, {1'b1, 11'h020, 32'h00000033});

        // Dual grant with rotation
        for (int i = 0; i < 4; i++) set_req(i, AW'(10 + i), 32'hA0 + i);
        req_valid = 4'hF;
        #1 chk("dual_ready0", req_ready, 4'b0011);
        tick;
        chk("dual_w1_c1", {w_enb_1, w_addr_1, w_din_1}, {1'b1, 11'd10, 32'hA0});
        chk("dual_w2_c1", {w_enb_2, w_addr_2, w_din_2}, {1'b1, 11'd11, 32'hA1});
        chk("dual_ready1", req_ready, 4'b1100);
        tick;
        chk("dual_w1_c2", {w_enb_1, w_addr_1, w_din_1}, {1'b1, 11'd12, 32'hA2});
        chk("dual_w2_c2", {w_enb_2, w_addr_2, w_din_2}, {1'b1, 11'd13, 32'hA3});
        chk("dual_ready2", req_ready, 4'b0011);
        tick;
        chk("dual_w1_c3", {w_enb_1, w_addr_1}, {1'b1, 11'd10});
        req_valid = 4'b0000;
        tick;
        chk("idle_enb", {w_enb_1, w_enb_2}, 2'b00);
        for (int i = 0; i < 4; i++) chk("dual_mem", mem[10 + i], 32'hA0 + i);
        chk("single_mem", mem[11'h005], 32'hDEADBEEF);

        // Same-address conflict, rr_ptr=2
        set_req(0, 11'h07F, 32'h1111);
        set_req(1, 11'h07F, 32'h2222);
        req_valid = 4'b0011;
        #1 chk("conf_ready0", req_ready, 4'b0001);
        tick;
        chk("conf_w1_c1", {w_enb_1, w_addr_1, w_din_1}, {1'b1, 11'h07F, 32'h1111});
        chk("conf_enb2_c1", w_enb_2, 1'b0);
        req_valid = 4'b0010;
        #1 chk("conf_ready1", req_ready, 4'b0010);
        tick;
        chk("conf_w1_c2", {w_enb_1, w_addr_1, w_din_1}, {1'b1, 11'h07F, 32'h2222});
        chk("conf_enb2_c2", w_enb_2, 1'b0);
        req_valid = 4'b0000;
        tick;
        chk("conf_mem", mem[11'h07F], 32'h2222);

        // Re-init while all requesters are valid; a second pulse inside INIT is ignored
        for (int i = 0; i < 4; i++) set_req(i, AW'(10 + i), 32'hB0 + i);
        req_valid  = 4'hF;
        init_start = 1'b1;
        #1 chk("reinit_ready", req_ready, 4'b0000);
        tick;
        init_start = 1'b0;
        chk("reinit_enb", {w_enb_1, w_enb_2}, 2'b00);
        chk("reinit_done", init_done, 1'b0);
        #1 chk("reinit_ready_init", req_ready, 4'b0000);
        req_valid = 4'b0000;
        for (int k = 0; k < 1024; k++) begin
            tick;
            init_start = (k == 5);
            chk_init_write(k);
            if (k == 0 || k == 1022 || k == 1023)
                chk("reinit_done_k", init_done, (k == 1023) ? 1'b1 : 1'b0);
        end
        init_start = 1'b0;
        tick;
        chk("reinit_mem_005", mem[11'h005], 32'h0);
        chk("reinit_mem_07F", mem[11'h07F], 32'h0);
        chk("reinit_mem_020", mem[11'h020], 32'h0);
        for (int i = 0; i < 4; i++) chk("reinit_mem_dual", mem[10 + i], 32'h0);

        // Reset mid-sweep at init_cnt=500
        init_start = 1'b1;
        tick;
        init_start = 1'b0;
        for (int j = 0; j < 500; j++) tick;
        chk_init_write(499);
        req_valid = 4'hF;
        rst = 1'b1;
        #1;
        chk("midrst_enb", {w_enb_1, w_enb_2}, 2'b00);
        chk("midrst_addr", {w_addr_1, w_addr_2}, '0);
        chk("midrst_din", {w_din_1, w_din_2}, '0);
        chk("midrst_done", init_done, 1'b0);
        chk("midrst_ready", req_ready, 4'b0000);
        tick; tick;
        chk("midrst_hold", {w_enb_1, w_enb_2}, 2'b00);
        rst = 1'b0;
        tick;
        chk_init_write(0);
        chk("restart_ready", req_ready, 4'b0000);
        tick;
        chk_init_write(1);
        req_valid = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lvt_wr_scheduler.md
Name: lvt_wr_scheduler

Overview:
Write-side controller for the 2R2W LVT memory. It shares the memory's two write ports among four write requesters using round-robin arbitration with a valid/ready handshake. It never issues two same-cycle writes to the same address, so the LVT entry is never written ambiguously. After reset, or on request, it sequences a full-memory initialisation sweep before granting any requester.

Parameters:
BLOCKSIZE, 10, address width is BLOCKSIZE+1 bits; depth DEPTH = 2<<BLOCKSIZE = 2048 words
DATA_W, 32, data word width
INIT_VALUE, 0, data written to every word during the init sweep

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
req_valid  in  4  per-requester write request
req_addr  in  4*(BLOCKSIZE+1)  requester i address in slice i
req_data  in  4*DATA_W  requester i data in slice i
req_ready  out  4  combinational grant; transfer when valid&ready
init_start  in  1  single-cycle pulse; re-runs the init sweep (honoured only in RUN)
init_done  out  1  high while in RUN
w_addr_1  out  BLOCKSIZE+1  memory write port 1 address (registered)
w_din_1  out  DATA_W  port 1 data (registered)
w_enb_1  out  1  port 1 enable (registered)
w_addr_2  out  BLOCKSIZE+1  memory write port 2 address (registered)
w_din_2  out  DATA_W  port 2 data (registered)
w_enb_2  out  1  port 2 enable (registered)

Behaviour:
- Reset (rst=1, async): state=INIT, init_cnt=0, rr_ptr=0, init_done=0, w_enb_1/2=0, w_addr_*=0, w_din_*=0. req_ready=0 while rst=1 and whenever state!=RUN.
- FSM states: INIT and RUN.
- INIT: on each posedge, the block registers w_enb_1=w_enb_2=1, w_addr_1=2*init_cnt, w_addr_2=2*init_cnt+1, w_din_*=INIT_VALUE, then increments init_cnt.
  - The sweep takes DEPTH/2 = 1024 cycles.
  - At the posedge that registers the write for init_cnt=DEPTH/2-1, the FSM moves to RUN and init_done becomes 1.
  - The last init write is therefore visible on the ports during the first RUN cycle.
- RUN, arbitration (combinational, each cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... (mod 4).
  - First valid requester A: granted to port 1.
  - Next valid requester B in scan order whose address != A's address: granted to port 2.
  - Valid requesters with an address equal to A's are skipped and stay pending.
  - At most two grants per cycle; req_ready is high only for A and B.
- RUN, issue (registered): at the posedge, w_enb_1 is set if A exists, w_enb_2 if B exists, with the corresponding address and data; otherwise the enables are 0. Issue latency is 1 cycle from handshake to write strobe.
- Round-robin: if any grant occurred, rr_ptr <= (index of last granted requester)+1 mod 4; otherwise rr_ptr is unchanged.
- Fairness: a continuously valid requester is granted within 2 cycles, given distinct addresses.
- init_start in RUN:
  - In that cycle, req_ready=0 and no grant is issued; the w_enb_* registered at that edge are 0.
  - Next state is INIT with init_cnt=0, and init_done falls at that edge.
  - Writes granted in earlier cycles complete normally.
- init_start in INIT is ignored.
- Reset asserted mid-INIT or mid-RUN: immediate return to the reset state and the sweep restarts from address 0. No partial write strobe is produced after rst rises.
- Address and counter arithmetic is unsigned. init_cnt is BLOCKSIZE bits and never wraps, because the state change occurs at the terminal count.
- Port assignment is fixed: port 2's write wins in the LVT only on the same address, which the arbiter forbids. Port ordering therefore carries no semantic meaning.

Test Plan:
- Reset release: rst 1->0. Expect w_enb_1/2=1 with addresses (0,1), (2,3), ..., (2046,2047) over 1024 consecutive cycles, data 0. init_done=1 from the next cycle on; req_ready=0 throughout INIT.
- Single requester: in RUN, req_valid=4'b0100, addr 0x005, data 0xDEADBEEF. Expect req_ready=4'b0100 the same cycle, and w_enb_1=1, w_addr_1=0x005, w_din_1=0xDEADBEEF the next cycle, with w_enb_2=0.
- Dual grant and rotation: all four valid with addresses 10/11/12/13 and rr_ptr=0. Grants are {0,1}, then {2,3}, then {0,1}, ..., with port 1 getting requesters 0, 2, 0. A readback through the 2R2W memory returns the written data.
- Same-address conflict: requesters 0 and 1 valid, both addr 0x07F, data 0x1111/0x2222. Cycle 1 grants only req0 on port 1; cycle 2 grants req1 on port 1. A final read of 0x07F returns 0x2222, and w_enb_2 is never 1.
- Re-init: pulse init_start while req_valid=4'hF. That cycle has req_ready=0; init_done falls and a 1024-cycle sweep follows. All previously written addresses then read INIT_VALUE.
- Reset mid-sweep: assert rst at init_cnt=500. Outputs drop to 0 immediately; after release the sweep restarts at addresses (0,1).
